// File: rtl/lift_call_scheduler.sv
// Collects hall and cab calls, picks the next floor with a SCAN (keep-direction) policy,
// hands it to the lift over valid/ready, then holds the doors open after arrival.
module lift_call_scheduler #(
   parameter int NUM_FLOORS = 8,
   parameter int FW         = 3,
   parameter int DWELL      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] hall_req,
   input  logic [NUM_FLOORS-1:0] cab_req,
   input  logic [FW-1:0]         elev_f,
   input  logic                  busy_i,
   output logic [FW-1:0]         tgt_f,
   output logic                  tgt_vld,
   input  logic                  tgt_rdy,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic                  dir_o,
   output logic                  door_open
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      MOVE  = 2'd2,
      DOOR  = 2'd3
   } state_t;

   state_t                state_r, state_s;
   logic [NUM_FLOORS-1:0] pending_r, clr_s, here_oh_s;
   logic                  here_s;
   logic                  dir_r, dir_s;
   logic [FW-1:0]         tgt_r, tgt_s;
   logic [CW-1:0]         cnt_r, cnt_s;
   logic                  tgt_vld_r, door_open_r;
   logic [FW-1:0]         up_f_s, dn_f_s;
   logic                  up_hit_s, dn_hit_s;

   // Out-of-range floor numbers map to an all-zero vector, i.e. no floor match.
   function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FW-1:0] f);
      logic [NUM_FLOORS-1:0] oh;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         oh[i] = (FW'(i) == f);
      end
      return oh;
   endfunction

   assign here_oh_s = floor_onehot(elev_f);
   assign here_s    = |(pending_r & here_oh_s);

   // Nearest pending call above (lowest) and below (highest) the current floor.
   always_comb begin
      up_hit_s = 1'b0;
      up_f_s   = {FW{1'b0}};
      dn_hit_s = 1'b0;
      dn_f_s   = {FW{1'b0}};
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_r[i] && (FW'(i) > elev_f)) begin
            up_hit_s = 1'b1;
            up_f_s   = FW'(i);
         end else begin
            up_hit_s = up_hit_s;
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_r[i] && (FW'(i) < elev_f)) begin
            dn_hit_s = 1'b1;
            dn_f_s   = FW'(i);
         end else begin
            dn_hit_s = dn_hit_s;
         end
      end
   end

   // Next-state, target selection and served-call clearing.
   always_comb begin
      state_s = state_r;
      dir_s   = dir_r;
      tgt_s   = tgt_r;
      cnt_s   = cnt_r;
      clr_s   = {NUM_FLOORS{1'b0}};
      case (state_r)
         IDLE: begin
            if (here_s) begin
               state_s = DOOR;
               cnt_s   = CW'(DWELL - 1);
               clr_s   = here_oh_s;
            end else if (pending_r != {NUM_FLOORS{1'b0}}) begin
               state_s = ISSUE;
               if (dir_r) begin
                  if (up_hit_s) begin
                     tgt_s = up_f_s;
                  end else begin
                     tgt_s = dn_f_s;
                     dir_s = 1'b0;
                  end
               end else begin
                  if (dn_hit_s) begin
                     tgt_s = dn_f_s;
                  end else begin
                     tgt_s = up_f_s;
                     dir_s = 1'b1;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (tgt_rdy) begin
               state_s = MOVE;
            end else begin
               state_s = ISSUE;
            end
         end
         MOVE: begin
            if ((elev_f == tgt_r) && !busy_i) begin
               state_s = DOOR;
               cnt_s   = CW'(DWELL - 1);
               clr_s   = floor_onehot(tgt_r);
            end else begin
               state_s = MOVE;
            end
         end
         DOOR: begin
            // A call at the floor while the doors are open counts as served.
            clr_s = here_oh_s;
            if (cnt_r == {CW{1'b0}}) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, pending calls and registered handshake/door outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         pending_r   <= {NUM_FLOORS{1'b0}};
         dir_r       <= 1'b1;
         tgt_r       <= {FW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         tgt_vld_r   <= 1'b0;
         door_open_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         pending_r   <= (pending_r | hall_req | cab_req) & ~clr_s;
         dir_r       <= dir_s;
         tgt_r       <= tgt_s;
         cnt_r       <= cnt_s;
         tgt_vld_r   <= (state_s == ISSUE);
         door_open_r <= (state_s == DOOR);
      end
   end

   assign tgt_f     = tgt_r;
   assign tgt_vld   = tgt_vld_r;
   assign pending_o = pending_r;
   assign dir_o     = dir_r;
   assign door_open = door_open_r;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboard bench: a transaction-level call/lift model predicts every post-edge output;
// a negedge monitor pops and compares. A simple lift model drives floor/busy.
module tb_lift_call_scheduler;

   localparam int NF    = 8;
   localparam int FW    = 3;
   localparam int DWELL = 4;
   localparam int P_IDLE = 0, P_OFFER = 1, P_TRAVEL = 2, P_DOOR = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] hall_req, cab_req, pending_o;
   logic [FW-1:0] elev_f, tgt_f;
   logic          busy_i, tgt_vld, tgt_rdy, dir_o, door_open;

   lift_call_scheduler #(.NUM_FLOORS(NF), .FW(FW), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .hall_req(hall_req), .cab_req(cab_req),
      .elev_f(elev_f), .busy_i(busy_i), .tgt_f(tgt_f), .tgt_vld(tgt_vld),
      .tgt_rdy(tgt_rdy), .pending_o(pending_o), .dir_o(dir_o), .door_open(door_open)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NF-1:0] pend;
      logic          vld;
      logic [FW-1:0] tgt;
      logic          dir;
      logic          door;
   } snap_t;

   snap_t exp_q[$];
   int    n_tests = 0, n_fail = 0;

   // reference model
   logic [NF-1:0] m_pend;
   logic          m_dir;
   logic [FW-1:0] m_tgt;
   int            m_phase, m_left;

   // lift model and stimulus controls
   logic [FW-1:0] lift_f = '0, lift_goal = '0;
   logic          lift_busy = 1'b0, lift_active = 1'b0;
   int            stall = 0, stall_force = -1, rdy_mode = 0;
   logic          rst_in = 1'b0;
   logic [NF-1:0] arr_hall = '0;
   logic          arr_hit = 1'b0;
   int            door_cnt = 0, vld_cnt = 0, gate_viol = 0;
   int            served[$], served_dir[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Nearest call in the travel direction; if none, reverse and take the nearest the other way.
   task automatic choose(input logic [FW-1:0] ef);
      int best, d, bd;
      for (int sweep = 0; sweep < 2; sweep++) begin
         best = -1;
         bd   = 1000;
         for (int f = 0; f < NF; f++) begin
            d = m_dir ? f - int'(ef) : int'(ef) - f;
            if (m_pend[f] && d > 0 && d < bd) begin
               best = f;
               bd   = d;
            end
         end
         if (best >= 0) begin
            m_tgt = FW'(best);
            return;
         end
         m_dir = ~m_dir;
      end
   endtask

   task automatic model_step(input logic r, input logic [NF-1:0] h, input logic [NF-1:0] c,
                             input logic [FW-1:0] ef, input logic busy, input logic rdy);
      logic [NF-1:0] clr;
      clr = '0;
      if (r) begin
         m_phase = P_IDLE; m_pend = '0; m_dir = 1'b1; m_tgt = '0; m_left = 0;
         return;
      end
      case (m_phase)
         P_IDLE: begin
            if (m_pend[ef]) begin
               clr[ef] = 1'b1; m_phase = P_DOOR; m_left = DWELL;
            end else if (m_pend != '0) begin
               choose(ef); m_phase = P_OFFER;
            end
         end
         P_OFFER: if (rdy) m_phase = P_TRAVEL;
         P_TRAVEL: begin
            if (ef == m_tgt && !busy) begin
               clr[m_tgt] = 1'b1; m_phase = P_DOOR; m_left = DWELL;
            end
         end
         default: begin
            clr[ef] = 1'b1;
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
         end
      endcase
      m_pend = (m_pend | h | c) & ~clr;
   endtask

   // One clock cycle: drive inputs, predict, push expectation, advance the lift.
   task automatic step(input logic [NF-1:0] hall_v, input logic [NF-1:0] cab_v);
      logic          rdy_v, accepted;
      logic [NF-1:0] h;
      logic [FW-1:0] goal;
      snap_t         e;
      case (rdy_mode)
         2: rdy_v = 1'b1;
         1: rdy_v = 1'($urandom_range(0, 1));
         default: rdy_v = 1'b0;
      endcase
      h = hall_v;
      if (arr_hall != '0 && m_phase == P_TRAVEL && lift_f == m_tgt && !lift_busy) begin
         h = h | arr_hall; arr_hall = '0; arr_hit = 1'b1;
      end
      if (door_open) door_cnt++;
      if (tgt_vld) vld_cnt++;
      if (door_open && lift_active && lift_busy) gate_viol++;
      accepted = (m_phase == P_OFFER) && rdy_v && !rst_in;
      if (accepted) begin
         served.push_back(int'(tgt_f));
         served_dir.push_back(int'(dir_o));
      end
      goal = m_tgt;
      rst = rst_in; hall_req = h; cab_req = cab_v; elev_f = lift_f; busy_i = lift_busy; tgt_rdy = rdy_v;
      model_step(rst_in, h, cab_v, lift_f, lift_busy, rdy_v);
      e.pend = m_pend; e.vld = (m_phase == P_OFFER); e.tgt = m_tgt; e.dir = m_dir;
      e.door = (m_phase == P_DOOR);
      @(posedge clk);
      exp_q.push_back(e);
      if (rst_in) begin
         lift_active = 1'b0; lift_busy = 1'b0;
      end else if (accepted) begin
         lift_active = 1'b1; lift_busy = 1'b1; lift_goal = goal;
         stall = (stall_force >= 0) ? stall_force : int'($urandom_range(0, 2));
      end else if (lift_active) begin
         if (lift_f != lift_goal) begin
            if ($urandom_range(0, 1) == 1) lift_f = (lift_f < lift_goal) ? lift_f + 3'd1 : lift_f - 3'd1;
         end else if (stall > 0) begin
            stall--;
         end else begin
            lift_busy = 1'b0; lift_active = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step('0, '0);
      rst_in = 1'b0;
   endtask

   task automatic drain(input int max_cycles, input string name);
      for (int i = 0; i < max_cycles && !(m_phase == P_IDLE && m_pend == '0); i++) step('0, '0);
      check({name, "_drained_pending"}, pending_o, 0);
      check({name, "_drained_door"}, door_open, 0);
   endtask

   // Monitor: compare every presented output against the oldest prediction.
   always @(negedge clk) begin
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pending_o", pending_o, e.pend);
         check("tgt_vld", tgt_vld, e.vld);
         check("tgt_f", tgt_f, e.tgt);
         check("dir_o", dir_o, e.dir);
         check("door_open", door_open, e.door);
      end
   end

   initial begin
      // first request, held-off handshake
      lift_f = 3'd0;
      do_reset();
      rdy_mode = 0;
      step('0, 8'h08);
      check("t1_pending", pending_o, 8'h08);
      check("t1_vld_early", tgt_vld, 0);
      step('0, '0);
      check("t1_vld", tgt_vld, 1);
      check("t1_tgt", tgt_f, 3);
      for (int i = 0; i < 5; i++) begin
         step('0, '0);
         check("t1_hold_vld", tgt_vld, 1);
         check("t1_hold_tgt", tgt_f, 3);
      end
      rdy_mode = 2;
      drain(200, "t1");

      // SCAN ordering from floor 4 going up
      lift_f = 3'd4;
      do_reset();
      rdy_mode = 1;
      served.delete(); served_dir.delete();
      step(8'hC2, '0);
      drain(400, "t2");
      check("t2_count", served.size(), 3);
      if (served.size() == 3) begin
         check("t2_first", served[0], 6);
         check("t2_second", served[1], 7);
         check("t2_third", served[2], 1);
         check("t2_dir_down", served_dir[2], 0);
      end

      // call at the current floor
      lift_f = 3'd2;
      do_reset();
      door_cnt = 0; vld_cnt = 0;
      step(8'h04, '0);
      check("t3_pending", pending_o, 8'h04);
      drain(50, "t3");
      check("t3_door_cycles", door_cnt, DWELL);
      check("t3_no_vld", vld_cnt, 0);

      // arrival at 5 with simultaneous calls at 5 and 0
      lift_f = 3'd0;
      do_reset();
      rdy_mode = 2;
      arr_hall = 8'h21; arr_hit = 1'b0;
      step('0, 8'h20);
      for (int i = 0; i < 100 && !arr_hit; i++) step('0, '0);
      check("t4_arrival_seen", arr_hit, 1);
      check("t4_pending", pending_o, 8'h01);
      check("t4_door", door_open, 1);
      arr_hall = '0;
      drain(200, "t4");

      // reset while moving
      lift_f = 3'd0;
      do_reset();
      rdy_mode = 2;
      step('0, 8'h90);
      for (int i = 0; i < 20 && m_phase != P_TRAVEL; i++) step('0, '0);
      check("t5_pre_pending", pending_o, 8'h90);
      check("t5_pre_vld", tgt_vld, 0);
      rst_in = 1'b1;
      step('0, '0);
      rst_in = 1'b0;
      check("t5_pending", pending_o, 0);
      check("t5_vld", tgt_vld, 0);
      check("t5_door", door_open, 0);
      check("t5_dir", dir_o, 1);
      check("t5_tgt", tgt_f, 0);

      // busy gating at the target floor
      lift_f = 3'd0;
      do_reset();
      rdy_mode = 2; stall_force = 3; gate_viol = 0; door_cnt = 0;
      step('0, 8'h08);
      drain(100, "t6");
      stall_force = -1;
      check("t6_gate", gate_viol, 0);
      check("t6_door_cycles", door_cnt, DWELL);

      // randomized traffic with occasional resets
      rdy_mode = 1;
      for (int i = 0; i < 800; i++) begin
         logic [NF-1:0] hv, cv;
         hv = ($urandom_range(0, 5) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
         cv = ($urandom_range(0, 5) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
         rst_in = ($urandom_range(0, 299) == 0);
         step(hv, cv);
      end
      rst_in = 1'b0;
      drain(3000, "rand");

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
